// File: rtl/aes_in_pack.sv
// Packs 32-bit words into 128-bit AES text blocks and queues up to NBLK of them.
// Latency: the block is presented on TextRaw the cycle after its 4th word is accepted, if the queue was empty.
// Backpressure: only a block-completing word stalls, while the queue is full; there is no Trdy->WrReady path.
module aes_in_pack #(
    parameter int NBLK   = 2,
    parameter bit LITTLE = 1'b0,
    localparam int AW    = $clog2(NBLK),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [31:0]   WrData,
    input  logic          WrValid,
    input  logic          WrLast,
    output logic          WrReady,
    output logic [127:0]  TextRaw,
    output logic          TextLast,
    output logic          TextIrdy,
    input  logic          TextTrdy,
    output logic [LW-1:0] Level,
    output logic          Err
);

    logic [1:0]    wcnt_q, wcnt_d;
    logic [AW-1:0] wp_q, rp_q;
    logic [LW-1:0] level_q, level_d;
    logic          err_q, err_d;
    logic [127:0]  asm_q, asm_ins;
    logic [127:0]  buf_q [NBLK];
    logic [NBLK-1:0] last_q;
    logic [127:0]  hold_raw_q;
    logic          hold_last_q;
    logic [1:0]    lane;
    logic          wr_acc, push, pop;

    assign WrReady  = ~((wcnt_q == 2'd3) && (level_q == LW'(NBLK)));
    assign TextIrdy = (level_q != '0);
    assign wr_acc   = WrValid & WrReady;
    assign push     = wr_acc & (wcnt_q == 2'd3);
    assign pop      = TextIrdy & TextTrdy;
    assign lane     = LITTLE ? wcnt_q : 2'd3 - wcnt_q;

    // The incoming word merged into the assembly register, so a completing word is pushed directly.
    always_comb begin
        asm_ins = asm_q;
        asm_ins[{lane, 5'd0} +: 32] = WrData;
    end

    always_comb begin
        wcnt_d  = wr_acc ? wcnt_q + 2'd1 : wcnt_q;
        err_d   = err_q | (wr_acc & WrLast & (wcnt_q != 2'd3));
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // With the queue empty the outputs replay the last presented block rather than stale entries.
    assign TextRaw  = TextIrdy ? buf_q[rp_q]  : hold_raw_q;
    assign TextLast = TextIrdy ? last_q[rp_q] : hold_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q      <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            level_q     <= '0;
            err_q       <= 1'b0;
            asm_q       <= '0;
            last_q      <= '0;
            hold_raw_q  <= '0;
            hold_last_q <= 1'b0;
            for (int i = 0; i < NBLK; i++) begin
                buf_q[i] <= '0;
            end
        end else if (clr) begin
            wcnt_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            level_q <= level_d;
            err_q   <= err_d;
            if (wr_acc) begin
                asm_q <= asm_ins;
            end
            if (push) begin
                buf_q[wp_q]  <= asm_ins;
                last_q[wp_q] <= WrLast;
                wp_q         <= wp_q + AW'(1);
            end
            if (pop) begin
                rp_q <= rp_q + AW'(1);
            end
            if (TextIrdy) begin
                hold_raw_q  <= buf_q[rp_q];
                hold_last_q <= last_q[rp_q];
            end
        end
    end

    assign Level = level_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_aes_in_pack.sv
// Drives two packers (big- and little-endian word order) with identical traffic and scores popped blocks.
module tb_aes_in_pack;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b0;
    logic [31:0]  WrData = '0;
    logic         WrValid = 1'b0;
    logic         WrLast = 1'b0;
    logic         TextTrdy = 1'b0;

    logic         wr_rdy0, last0, irdy0, err0;
    logic [127:0] raw0;
    logic [1:0]   lvl0;
    logic         wr_rdy1, last1, irdy1, err1;
    logic [127:0] raw1;
    logic [1:0]   lvl1;

    int checks = 0;
    int errors = 0;
    logic [128:0] q0[$];
    logic [128:0] q1[$];

    localparam logic [127:0] B1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] B1L = 128'hCCDDEEFF_8899AABB_44556677_00112233;
    localparam logic [127:0] B2  = 128'h10000001_10000002_10000003_10000004;
    localparam logic [127:0] B3  = 128'h20000001_20000002_20000003_20000004;
    localparam logic [127:0] B4  = 128'h30000001_30000002_30000003_30000004;
    localparam logic [127:0] B5  = 128'h40000001_40000002_40000003_40000004;
    localparam logic [127:0] B6  = 128'h50000001_50000002_50000003_50000004;
    localparam logic [127:0] B6L = 128'h50000004_50000003_50000002_50000001;
    localparam logic [127:0] B7  = 128'h60000001_60000002_60000003_60000004;
    localparam logic [127:0] B8  = 128'h70000001_70000002_70000003_70000004;
    localparam logic [127:0] B9  = 128'h80000001_80000002_80000003_80000004;
    localparam logic [127:0] B10 = 128'h90000001_90000002_90000003_90000004;
    localparam logic [127:0] B11 = 128'hA0000001_A0000002_A0000003_A0000004;
    localparam logic [127:0] B12 = 128'hB0000001_B0000002_B0000003_B0000004;
    localparam logic [127:0] B13 = 128'hC0000001_C0000002_C0000003_C0000004;
    localparam logic [127:0] B13L = 128'hC0000004_C0000003_C0000002_C0000001;

    aes_in_pack #(.NBLK(2), .LITTLE(1'b0)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .WrData(WrData), .WrValid(WrValid), .WrLast(WrLast), .WrReady(wr_rdy0),
        .TextRaw(raw0), .TextLast(last0), .TextIrdy(irdy0), .TextTrdy(TextTrdy),
        .Level(lvl0), .Err(err0)
    );

    aes_in_pack #(.NBLK(2), .LITTLE(1'b1)) dut_l (
        .clk(clk), .rst(rst), .clr(clr),
        .WrData(WrData), .WrValid(WrValid), .WrLast(WrLast), .WrReady(wr_rdy1),
        .TextRaw(raw1), .TextLast(last1), .TextIrdy(irdy1), .TextTrdy(TextTrdy),
        .Level(lvl1), .Err(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkl(input string nm, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] swap(input logic [127:0] b);
        return {b[31:0], b[63:32], b[95:64], b[127:96]};
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
        return b[127 - 32*i -: 32];
    endfunction

    task automatic exp_push(input logic [127:0] b, input logic l);
        q0.push_back({l, b});
        q1.push_back({l, swap(b)});
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int n;
        WrData  = d;
        WrLast  = l;
        WrValid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!wr_rdy0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chkb("wrready_wait", wr_rdy0, 1'b1);
        @(posedge clk);
        #1;
        WrValid = 1'b0;
        WrLast  = 1'b0;
    endtask

    // li selects which word carries WrLast; values outside 0..3 mean none.
    task automatic send_part(input logic [127:0] b, input int li, input int nw);
        for (int i = 0; i < nw; i++) begin
            send_word(word_of(b, i), i == li);
        end
    endtask

    task automatic send_blk(input logic [127:0] b, input int li);
        exp_push(b, li == 3);
        send_part(b, li, 4);
    endtask

    task automatic pop_one;
        TextTrdy = 1'b1;
        @(posedge clk);
        #1;
        TextTrdy = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chkb({nm, "_wrready"}, wr_rdy0, 1'b1);
        chkb({nm, "_irdy"}, irdy0, 1'b0);
        chk({nm, "_raw"}, raw0, 128'h0);
        chk({nm, "_raw_little"}, raw1, 128'h0);
        chkb({nm, "_last"}, last0, 1'b0);
        chkl({nm, "_level"}, lvl0, 2'd0);
        chkb({nm, "_err"}, err0, 1'b0);
    endtask

    // Scoreboard monitor: a pop handshake seen mid-cycle completes on the next rising edge.
    initial begin
        logic [128:0] e;
        forever begin
            @(negedge clk);
            if (rst && !clr && irdy0 && TextTrdy) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pop_unexpected_big: got %h expected none", raw0);
                end else begin
                    e = q0.pop_front();
                    chk("pop_raw_big", raw0, e[127:0]);
                    chkb("pop_last_big", last0, e[128]);
                end
            end
            if (rst && !clr && irdy1 && TextTrdy) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pop_unexpected_little: got %h expected none", raw1);
                end else begin
                    e = q1.pop_front();
                    chk("pop_raw_little", raw1, e[127:0]);
                    chkb("pop_last_little", last1, e[128]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        #12;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill one block, check presentation one edge after the 4th word.
        send_blk(B1, 3);
        chkb("fill_irdy", irdy0, 1'b1);
        chkl("fill_level", lvl0, 2'd1);
        chk("fill_raw", raw0, B1);
        chk("fill_raw_little", raw1, B1L);
        chkb("fill_last", last0, 1'b1);
        pop_one();
        chkl("drain1_level", lvl0, 2'd0);
        chkb("drain1_irdy", irdy0, 1'b0);

        // Full backpressure on the 12th word.
        send_blk(B2, 3);
        send_blk(B3, 4);
        exp_push(B4, 1'b0);
        send_part(B4, 4, 3);
        chkb("full_err_clear", err0, 1'b0);
        WrData  = word_of(B4, 3);
        WrValid = 1'b1;
        @(negedge clk);
        chkb("full_wrready_low", wr_rdy0, 1'b0);
        chkl("full_level", lvl0, 2'd2);
        @(negedge clk);
        chkb("full_wrready_held", wr_rdy0, 1'b0);
        @(posedge clk);
        #1;
        TextTrdy = 1'b1;
        @(negedge clk);
        chkb("full_no_comb_path", wr_rdy0, 1'b0);
        @(posedge clk);
        #1;
        TextTrdy = 1'b0;
        @(negedge clk);
        chkb("full_wrready_after_pop", wr_rdy0, 1'b1);
        chkl("full_level_after_pop", lvl0, 2'd1);
        @(posedge clk);
        #1;
        WrValid = 1'b0;
        chkl("full_level_refill", lvl0, 2'd2);

        // Simultaneous push and pop.
        TextTrdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        TextTrdy = 1'b0;
        chkl("drain2_level", lvl0, 2'd0);
        send_blk(B5, 3);
        exp_push(B6, 1'b1);
        send_part(B6, 4, 3);
        WrData   = word_of(B6, 3);
        WrLast   = 1'b1;
        WrValid  = 1'b1;
        TextTrdy = 1'b1;
        @(posedge clk);
        #1;
        WrValid  = 1'b0;
        WrLast   = 1'b0;
        TextTrdy = 1'b0;
        chkl("pushpop_level", lvl0, 2'd1);
        chk("pushpop_raw", raw0, B6);
        chk("pushpop_raw_little", raw1, B6L);
        pop_one();

        // Misplaced WrLast sets sticky Err; clr flushes.
        exp_push(B7, 1'b0);
        send_part(B7, 1, 4);
        chkb("err_set", err0, 1'b1);
        chkb("err_head_last", last0, 1'b0);
        send_blk(B8, 3);
        chkb("err_sticky", err0, 1'b1);
        chkl("err_level", lvl0, 2'd2);
        send_part(B9, 4, 2);
        clr      = 1'b1;
        WrData   = 32'hDEADBEEF;
        WrValid  = 1'b1;
        TextTrdy = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        clr      = 1'b0;
        WrValid  = 1'b0;
        TextTrdy = 1'b0;
        chkb("clr_err", err0, 1'b0);
        chkl("clr_level", lvl0, 2'd0);
        chkb("clr_irdy", irdy0, 1'b0);
        chkb("clr_wrready", wr_rdy0, 1'b1);
        send_blk(B10, 3);
        chkl("postclr_level", lvl0, 2'd1);
        chk("postclr_raw", raw0, B10);
        pop_one();

        // Asynchronous reset in the middle of a block.
        send_blk(B11, 0);
        chkb("prerst_err", err0, 1'b1);
        send_part(B12, 4, 2);
        #2;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_blk(B13, 3);
        chkl("postrst_level", lvl0, 2'd1);
        chk("postrst_raw", raw0, B13);
        chk("postrst_raw_little", raw1, B13L);
        pop_one();

        repeat (3) @(posedge clk);
        #1;
        chkl("final_level", lvl0, 2'd0);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d/%0d expected 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
